// File: rtl/edit_mode_controller_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : edit_ctrl_pkg                                                   |
// | Desc   : Shared types, key indices and default timing for edit control.  |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
package edit_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_VIEW = 1'b0,
        ST_EDIT = 1'b1
    } state_t;

    localparam int K_MODE   = 0;
    localparam int K_SEL    = 1;
    localparam int K_UP     = 2;
    localparam int K_DOWN   = 3;
    localparam int NUM_KEYS = 4;

    localparam int c_DEF_DEBOUNCE_CYC  = 500_000;
    localparam int c_DEF_NUM_SCREENS   = 3;
    localparam int c_DEF_MAX_POS       = 7;
    localparam int c_DEF_IDLE_TIMEOUT  = 500_000_000;
    localparam int c_DEF_BLINK_HALF    = 12_500_000;
    localparam int c_DEF_REPEAT_DELAY  = 25_000_000;
    localparam int c_DEF_REPEAT_PERIOD = 5_000_000;

    // Counter width for a modulus n; never below one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/edit_mode_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : edit_mode_controller_if                                         |
// | Desc   : Raw key inputs and edit/screen/strobe outputs of the sequencer. |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
interface edit_mode_controller_if;
    logic       KeyModeN;
    logic       KeySelN;
    logic       KeyUpN;
    logic       KeyDownN;
    logic       EditMode;
    logic [2:0] EditPos;
    logic [1:0] screen;
    logic       KeyPlus;
    logic       KeyMinus;
    logic       BlinkOn;

    modport master (
        output KeyModeN, KeySelN, KeyUpN, KeyDownN,
        input  EditMode, EditPos, screen, KeyPlus, KeyMinus, BlinkOn
    );

    modport slave (
        input  KeyModeN, KeySelN, KeyUpN, KeyDownN,
        output EditMode, EditPos, screen, KeyPlus, KeyMinus, BlinkOn
    );
endinterface
`default_nettype wire

// File: rtl/edit_mode_controller_key_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : key_conditioner                                                 |
// | Desc   : 2-flop sync, debounce and press-edge pulse for one active-low   |
// |          push-button.                                                    |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module key_conditioner
    import edit_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = c_DEF_DEBOUNCE_CYC
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_key_n,
    output logic      o_pressed,
    output logic      o_press
);

    localparam int             c_CW       = cnt_width(DEBOUNCE_CYC);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DEBOUNCE_CYC - 1);

    logic [1:0]      r_sync;
    logic            r_state;   // accepted raw level, 1 = released
    logic [c_CW-1:0] r_cnt;
    logic            r_press;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= 2'b11;
            r_state <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_key_n};
            r_press <= 1'b0;
            // Any cycle agreeing with the accepted level restarts the count.
            if (r_sync[1] == r_state) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_state <= r_sync[1];
                r_cnt   <= '0;
                r_press <= ~r_sync[1];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_pressed = ~r_state;
    assign o_press   = r_press;

endmodule
`default_nettype wire

// File: rtl/edit_mode_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : edit_mode_controller                                            |
// | Desc   : Button front-end: edit FSM, digit/screen rotation, idle timeout,|
// |          blink and +/- strobes. Optional auto-repeat: AUTO_REPEAT_EN.    |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module edit_mode_controller
    import edit_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC  = c_DEF_DEBOUNCE_CYC,
    parameter int NUM_SCREENS   = c_DEF_NUM_SCREENS,
    parameter int MAX_POS       = c_DEF_MAX_POS,
    parameter int IDLE_TIMEOUT  = c_DEF_IDLE_TIMEOUT,
    parameter int BLINK_HALF    = c_DEF_BLINK_HALF,
    parameter int REPEAT_DELAY  = c_DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = c_DEF_REPEAT_PERIOD
) (
    input  wire logic             clk,
    input  wire logic             reset,
    edit_mode_controller_if.slave bus
);

    localparam int              c_IW         = cnt_width(IDLE_TIMEOUT);
    localparam int              c_BW         = cnt_width(BLINK_HALF);
    localparam logic [c_IW-1:0] c_IDLE_LAST  = c_IW'(IDLE_TIMEOUT - 1);
    localparam logic [c_BW-1:0] c_BLINK_LAST = c_BW'(BLINK_HALF - 1);
    localparam logic [2:0]      c_POS_MAX    = 3'(MAX_POS);
    localparam logic [1:0]      c_SCR_LAST   = 2'(NUM_SCREENS - 1);

    logic [NUM_KEYS-1:0] w_key_n;
    logic [NUM_KEYS-1:0] w_level;
    logic [NUM_KEYS-1:0] w_press;

    assign w_key_n[K_MODE] = bus.KeyModeN;
    assign w_key_n[K_SEL]  = bus.KeySelN;
    assign w_key_n[K_UP]   = bus.KeyUpN;
    assign w_key_n[K_DOWN] = bus.KeyDownN;

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_keys
        key_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key (
            .clk       (clk),
            .reset     (reset),
            .i_key_n   (w_key_n[gi]),
            .o_pressed (w_level[gi]),
            .o_press   (w_press[gi])
        );
    end

    logic w_ev_mode, w_ev_sel, w_ev_up, w_ev_down, w_any;
    assign w_ev_mode = w_press[K_MODE];
    assign w_ev_sel  = w_press[K_SEL] & ~w_press[K_MODE];
    assign w_ev_up   = w_press[K_UP] & ~(w_press[K_MODE] | w_press[K_SEL]);
    assign w_ev_down = w_press[K_DOWN] & ~(w_press[K_MODE] | w_press[K_SEL] | w_press[K_UP]);
    assign w_any     = |w_press;

    state_t          r_state;
    logic [2:0]      r_pos;
    logic [1:0]      r_screen;
    logic            r_plus;
    logic            r_minus;
    logic            r_blink;
    logic [c_BW-1:0] r_blink_cnt;
    logic [c_IW-1:0] r_idle;
    logic            w_rep_plus;
    logic            w_rep_minus;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_VIEW;
            r_pos       <= c_POS_MAX;
            r_screen    <= 2'd0;
            r_plus      <= 1'b1;
            r_minus     <= 1'b1;
            r_blink     <= 1'b1;
            r_blink_cnt <= '0;
            r_idle      <= '0;
        end else begin
            r_plus  <= 1'b1;
            r_minus <= 1'b1;
            case (r_state)
                ST_VIEW: begin
                    r_blink     <= 1'b1;
                    r_blink_cnt <= '0;
                    r_idle      <= '0;
                    if (w_ev_mode) begin
                        r_state <= ST_EDIT;
                        r_pos   <= c_POS_MAX;
                    end else if (w_ev_sel) begin
                        r_screen <= (r_screen == c_SCR_LAST) ? 2'd0 : r_screen + 2'd1;
                    end
                end
                ST_EDIT: begin
                    if (w_any || w_rep_plus || w_rep_minus) r_idle <= '0;
                    else                                    r_idle <= r_idle + 1'b1;
                    if (r_blink_cnt == c_BLINK_LAST) begin
                        r_blink     <= ~r_blink;
                        r_blink_cnt <= '0;
                    end else begin
                        r_blink_cnt <= r_blink_cnt + 1'b1;
                    end
                    // Events outrank repeat strobes, which outrank the timeout.
                    if (w_ev_mode) begin
                        r_state <= ST_VIEW;
                        r_blink <= 1'b1;
                    end else if (w_ev_sel) begin
                        r_pos       <= (r_pos == 3'd0) ? c_POS_MAX : r_pos - 3'd1;
                        r_blink     <= 1'b1;
                        r_blink_cnt <= '0;
                    end else if (w_ev_up || w_rep_plus) begin
                        r_plus <= 1'b0;
                    end else if (w_ev_down || w_rep_minus) begin
                        r_minus <= 1'b0;
                    end else if (r_idle == c_IDLE_LAST) begin
                        r_state <= ST_VIEW;
                        r_blink <= 1'b1;
                    end
                end
                default: r_state <= ST_VIEW;
            endcase
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int              c_RW       = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam logic [c_RW-1:0] c_DLY_LAST = c_RW'(REPEAT_DELAY - 1);
    localparam logic [c_RW-1:0] c_PER_LAST = c_RW'(REPEAT_PERIOD - 1);

    logic            r_rep_active;
    logic            r_rep_key;     // 0 = up, 1 = down
    logic            r_rep_period;
    logic [c_RW-1:0] r_rep_cnt;
    logic            w_rep_held;
    logic [c_RW-1:0] w_rep_last;
    logic            w_rep_due;
    logic            w_unused_lvl;

    assign w_rep_held   = r_rep_key ? w_level[K_DOWN] : w_level[K_UP];
    assign w_rep_last   = r_rep_period ? c_PER_LAST : c_DLY_LAST;
    assign w_rep_due    = r_rep_active & w_rep_held & (r_rep_cnt == w_rep_last)
                        & ~w_any & (r_state == ST_EDIT);
    assign w_rep_plus   = w_rep_due & ~r_rep_key;
    assign w_rep_minus  = w_rep_due & r_rep_key;
    assign w_unused_lvl = w_level[K_MODE] ^ w_level[K_SEL];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rep_active <= 1'b0;
            r_rep_key    <= 1'b0;
            r_rep_period <= 1'b0;
            r_rep_cnt    <= '0;
        end else if (r_state != ST_EDIT || w_ev_mode) begin
            r_rep_active <= 1'b0;
        end else if (w_ev_up || w_ev_down) begin
            r_rep_active <= 1'b1;
            r_rep_key    <= w_ev_down;
            r_rep_period <= 1'b0;
            r_rep_cnt    <= '0;
        end else if (!w_rep_held) begin
            r_rep_active <= 1'b0;
        end else if (r_rep_active) begin
            if (r_rep_cnt == w_rep_last) begin
                r_rep_cnt    <= '0;
                r_rep_period <= 1'b1;
            end else begin
                r_rep_cnt <= r_rep_cnt + 1'b1;
            end
        end
    end
`else
    logic w_unused_lvl;
    assign w_rep_plus   = 1'b0;
    assign w_rep_minus  = 1'b0;
    assign w_unused_lvl = ^{w_level, 32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

    assign bus.EditMode = (r_state == ST_EDIT);
    assign bus.EditPos  = r_pos;
    assign bus.screen   = r_screen;
    assign bus.KeyPlus  = r_plus;
    assign bus.KeyMinus = r_minus;
    assign bus.BlinkOn  = r_blink;

endmodule
`default_nettype wire
